// File: rtl/adr_decode_stage_pkg.sv
// Shared types for the decode stage: operation classes, opcode constants and
// the immediate-format selector used by the immediate generator.
package adr_decode_stage_pkg;

  typedef enum logic [5:0] {
    OPT_NOP     = 6'd0,
    OPT_R_ALU   = 6'd1,
    OPT_I_ALU   = 6'd2,
    OPT_LOAD    = 6'd3,
    OPT_STORE   = 6'd4,
    OPT_BRANCH  = 6'd5,
    OPT_JAL     = 6'd6,
    OPT_JALR    = 6'd7,
    OPT_LUI     = 6'd8,
    OPT_AUIPC   = 6'd9,
    OPT_FENCE   = 6'd10,
    OPT_SYSTEM  = 6'd11,
    OPT_ILLEGAL = 6'd12
  } adr_optype_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic imm_fmt_e imm_fmt_of(input adr_optype_e opt);
    imm_fmt_e fmt;
    case (opt)
      OPT_I_ALU, OPT_LOAD, OPT_JALR, OPT_SYSTEM: fmt = IMM_I;
      OPT_STORE:                                 fmt = IMM_S;
      OPT_BRANCH:                                fmt = IMM_B;
      OPT_LUI, OPT_AUIPC:                        fmt = IMM_U;
      OPT_JAL:                                   fmt = IMM_J;
      default:                                   fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/adr_decode_stage_imm_gen.sv
// Combinational immediate generator: picks the RV32 immediate layout selected
// by fmt and sign-extends the 32-bit result to XLEN.
module adr_imm_gen
  import adr_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{21{inst[31]}}, inst[30:20]};
      IMM_S:   imm32 = {{21{inst[31]}}, inst[30:25], inst[11:7]};
      IMM_B:   imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/adr_decode_stage.sv
// RV32I/E decode stage: classifies the instruction, builds its immediate and
// holds the result in a single valid/ready pipeline slot.
module adr_decode_stage
  import adr_decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PC_LEN       = 32,
  parameter int INST_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    if_de_valid_i,
  output logic                    if_de_ready_o,
  input  logic [INST_LEN-1:0]     if_de_inst_i,
  input  logic [PC_LEN-1:0]       if_de_pc_i,
  output logic [REG_ADDR_LEN-1:0] de_regfile_addr_a_o,
  output logic [REG_ADDR_LEN-1:0] de_regfile_addr_b_o,
  input  logic [XLEN-1:0]         regfile_de_data_a_i,
  input  logic [XLEN-1:0]         regfile_de_data_b_i,
  output logic                    de_ex_valid_o,
  input  logic                    de_ex_ready_i,
  output logic [5:0]              de_ex_optype_o,
  output logic [2:0]              de_ex_funct3_o,
  output logic [6:0]              de_ex_funct7_o,
  output logic [REG_ADDR_LEN-1:0] de_ex_rd_o,
  output logic [XLEN-1:0]         de_ex_data_a_o,
  output logic [XLEN-1:0]         de_ex_data_b_o,
  output logic [XLEN-1:0]         de_ex_data_imm_o,
  output logic [PC_LEN-1:0]       de_ex_pc_o,
  output logic                    de_ex_illegal_o
);

  // Handshake: a transfer happens on an edge where valid && ready. The slot
  // accepts when empty or when execute drains it in the same cycle.
  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  adr_optype_e     opt_base;
  adr_optype_e     opt_dec;
  adr_optype_e     optype_q;
  logic            use_rs1;
  logic            use_rs2;
  logic            use_rd;
  logic            reg_bad;
  logic            load;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm;

  assign inst   = if_de_inst_i[31:0];
  assign opcode = inst[6:0];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  assign de_regfile_addr_a_o = REG_ADDR_LEN'(rs1);
  assign de_regfile_addr_b_o = REG_ADDR_LEN'(rs2);

  always_comb begin
    opt_base = OPT_ILLEGAL;
    case (opcode)
      OPC_OP:     opt_base = OPT_R_ALU;
      OPC_OP_IMM: opt_base = OPT_I_ALU;
      OPC_LOAD:   opt_base = OPT_LOAD;
      OPC_STORE:  opt_base = OPT_STORE;
      OPC_BRANCH: opt_base = OPT_BRANCH;
      OPC_JAL:    opt_base = OPT_JAL;
      OPC_JALR:   opt_base = OPT_JALR;
      OPC_LUI:    opt_base = OPT_LUI;
      OPC_AUIPC:  opt_base = OPT_AUIPC;
      OPC_FENCE:  opt_base = OPT_FENCE;
      OPC_SYSTEM: opt_base = OPT_SYSTEM;
      default:    opt_base = OPT_ILLEGAL;
    endcase
  end

  // FENCE and SYSTEM carry rs1/rd fields in I-type position; they count as used.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opt_base)
      OPT_R_ALU: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OPT_I_ALU, OPT_LOAD, OPT_JALR, OPT_FENCE, OPT_SYSTEM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPT_STORE, OPT_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPT_JAL, OPT_LUI, OPT_AUIPC: use_rd = 1'b1;
      default: ;
    endcase
  end

  assign reg_bad = (use_rs1 && (int'(rs1) >= NUM_REGS)) ||
                   (use_rs2 && (int'(rs2) >= NUM_REGS)) ||
                   (use_rd  && (int'(rd)  >= NUM_REGS));

  assign opt_dec = (reg_bad || (inst[1:0] != 2'b11)) ? OPT_ILLEGAL : opt_base;
  assign fmt     = imm_fmt_of(opt_dec);

  adr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  assign if_de_ready_o = !de_ex_valid_o || de_ex_ready_i;
  assign load          = if_de_valid_i && if_de_ready_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      de_ex_valid_o    <= 1'b0;
      optype_q         <= OPT_NOP;
      de_ex_funct3_o   <= '0;
      de_ex_funct7_o   <= '0;
      de_ex_rd_o       <= '0;
      de_ex_data_a_o   <= '0;
      de_ex_data_b_o   <= '0;
      de_ex_data_imm_o <= '0;
      de_ex_pc_o       <= '0;
    end else if (flush_i) begin
      de_ex_valid_o <= 1'b0;
    end else if (load) begin
      de_ex_valid_o    <= 1'b1;
      optype_q         <= opt_dec;
      de_ex_funct3_o   <= inst[14:12];
      de_ex_funct7_o   <= inst[31:25];
      de_ex_rd_o       <= REG_ADDR_LEN'(rd);
      de_ex_data_a_o   <= regfile_de_data_a_i;
      de_ex_data_b_o   <= regfile_de_data_b_i;
      de_ex_data_imm_o <= imm;
      de_ex_pc_o       <= if_de_pc_i;
    end else if (de_ex_ready_i) begin
      de_ex_valid_o <= 1'b0;
    end
  end

  assign de_ex_optype_o  = optype_q;
  assign de_ex_illegal_o = (optype_q == OPT_ILLEGAL);

endmodule

// File: tb/tb_adr_decode_stage.sv
// Bench for adr_decode_stage: an RV32I and an RV32E instance share stimulus;
// a reference decoder fills an expected queue that a monitor drains.
module tb_adr_decode_stage;

  localparam logic [5:0] T_NOP = 6'd0, T_R = 6'd1, T_I = 6'd2, T_LD = 6'd3,
    T_ST = 6'd4, T_BR = 6'd5, T_JAL = 6'd6, T_JALR = 6'd7, T_LUI = 6'd8,
    T_AUIPC = 6'd9, T_FENCE = 6'd10, T_SYS = 6'd11, T_ILL = 6'd12;

  typedef struct packed {
    logic [5:0]  opt32;
    logic [5:0]  opt16;
    logic [31:0] imm32;
    logic [31:0] imm16;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [31:0] regs [32];

  logic ready, valid, illegal, ready_e, valid_e, illegal_e;
  logic [4:0] addr_a, addr_b, rd, addr_a_e, addr_b_e, rd_e;
  logic [5:0] optype, optype_e;
  logic [2:0] funct3, funct3_e;
  logic [6:0] funct7, funct7_e;
  logic [31:0] data_a, data_b, imm, pc, data_a_e, data_b_e, imm_e, pc_e;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  adr_decode_stage #(.NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .if_de_valid_i(in_valid),
    .if_de_ready_o(ready), .if_de_inst_i(in_inst), .if_de_pc_i(in_pc),
    .de_regfile_addr_a_o(addr_a), .de_regfile_addr_b_o(addr_b),
    .regfile_de_data_a_i(regs[addr_a]), .regfile_de_data_b_i(regs[addr_b]),
    .de_ex_valid_o(valid), .de_ex_ready_i(out_ready), .de_ex_optype_o(optype),
    .de_ex_funct3_o(funct3), .de_ex_funct7_o(funct7), .de_ex_rd_o(rd),
    .de_ex_data_a_o(data_a), .de_ex_data_b_o(data_b), .de_ex_data_imm_o(imm),
    .de_ex_pc_o(pc), .de_ex_illegal_o(illegal)
  );

  adr_decode_stage #(.NUM_REGS(16)) dut_e (
    .clk(clk), .reset(reset), .flush_i(flush), .if_de_valid_i(in_valid),
    .if_de_ready_o(ready_e), .if_de_inst_i(in_inst), .if_de_pc_i(in_pc),
    .de_regfile_addr_a_o(addr_a_e), .de_regfile_addr_b_o(addr_b_e),
    .regfile_de_data_a_i(regs[addr_a_e]), .regfile_de_data_b_i(regs[addr_b_e]),
    .de_ex_valid_o(valid_e), .de_ex_ready_i(out_ready), .de_ex_optype_o(optype_e),
    .de_ex_funct3_o(funct3_e), .de_ex_funct7_o(funct7_e), .de_ex_rd_o(rd_e),
    .de_ex_data_a_o(data_a_e), .de_ex_data_b_o(data_b_e), .de_ex_data_imm_o(imm_e),
    .de_ex_pc_o(pc_e), .de_ex_illegal_o(illegal_e)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference decoder: class from the opcode table, immediates by arithmetic shifts.
  function automatic void ref_dec(input logic [31:0] i, input int nregs,
                                  output logic [5:0] opt, output logic [31:0] im);
    int si;
    bit u1, u2, ud;
    si = int'($signed(i));
    u1 = 0; u2 = 0; ud = 0;
    im = 32'h0;
    case (i[6:0])
      7'b0110011: begin opt = T_R;     u1 = 1; u2 = 1; ud = 1; end
      7'b0010011: begin opt = T_I;     u1 = 1; ud = 1; im = 32'(si >>> 20); end
      7'b0000011: begin opt = T_LD;    u1 = 1; ud = 1; im = 32'(si >>> 20); end
      7'b1100111: begin opt = T_JALR;  u1 = 1; ud = 1; im = 32'(si >>> 20); end
      7'b1110011: begin opt = T_SYS;   u1 = 1; ud = 1; im = 32'(si >>> 20); end
      7'b0001111: begin opt = T_FENCE; u1 = 1; ud = 1; end
      7'b0100011: begin
        opt = T_ST; u1 = 1; u2 = 1;
        im = 32'((si >>> 25) << 5) | 32'(i[11:7]);
      end
      7'b1100011: begin
        opt = T_BR; u1 = 1; u2 = 1;
        im = 32'((si >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      7'b0110111: begin opt = T_LUI;   ud = 1; im = i & 32'hFFFFF000; end
      7'b0010111: begin opt = T_AUIPC; ud = 1; im = i & 32'hFFFFF000; end
      7'b1101111: begin
        opt = T_JAL; ud = 1;
        im = 32'((si >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      default: opt = T_ILL;
    endcase
    if ((u1 && int'(i[19:15]) >= nregs) || (u2 && int'(i[24:20]) >= nregs) ||
        (ud && int'(i[11:7]) >= nregs))
      opt = T_ILL;
    if (opt == T_ILL) im = 32'h0;
  endfunction

  // Stimulus side: whatever is accepted at this edge becomes the expected slot.
  always @(posedge clk) begin
    exp_t e;
    bit acc;
    acc = (exp_q.size() == 0) || out_ready;
    if (reset || flush) begin
      exp_q.delete();
    end else if (in_valid && acc) begin
      ref_dec(in_inst, 32, e.opt32, e.imm32);
      ref_dec(in_inst, 16, e.opt16, e.imm16);
      e.f3 = in_inst[14:12];
      e.f7 = in_inst[31:25];
      e.rd = in_inst[11:7];
      e.da = regs[in_inst[19:15]];
      e.db = regs[in_inst[24:20]];
      e.pc = in_pc;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares the presented slot every cycle and retires it when consumed.
  always @(negedge clk) begin
    exp_t e;
    bit ev;
    if (mon_en) begin
      ev = exp_q.size() != 0;
      chk("valid", 32'(valid), 32'(ev));
      chk("valid_e", 32'(valid_e), 32'(ev));
      chk("ready", 32'(ready), 32'(!ev || out_ready));
      chk("addr_a", 32'(addr_a), 32'(in_inst[19:15]));
      chk("addr_b", 32'(addr_b), 32'(in_inst[24:20]));
      if (ev) begin
        e = exp_q[0];
        chk("optype", 32'(optype), 32'(e.opt32));
        chk("illegal", 32'(illegal), 32'(e.opt32 == T_ILL));
        chk("imm", imm, e.imm32);
        chk("funct3", 32'(funct3), 32'(e.f3));
        chk("funct7", 32'(funct7), 32'(e.f7));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("data_a", data_a, e.da);
        chk("data_b", data_b, e.db);
        chk("pc", pc, e.pc);
        chk("optype_e", 32'(optype_e), 32'(e.opt16));
        chk("illegal_e", 32'(illegal_e), 32'(e.opt16 == T_ILL));
        chk("imm_e", imm_e, e.imm16);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic rdy, input logic fl, input logic rst);
    in_valid = v; in_inst = i; in_pc = p; out_ready = rdy; flush = fl; reset = rst;
    regs[$urandom_range(0, 31)] = $urandom();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI   = 32'hFFF10093;
  localparam logic [31:0] SW     = 32'hFE112E23;
  localparam logic [31:0] LUI    = 32'h123452B7;
  localparam logic [31:0] JAL    = 32'hFFFFF0EF;
  localparam logic [31:0] BADOP  = 32'h0000007F;
  localparam logic [31:0] ADDI16 = 32'h01000093;
  localparam logic [31:0] ADDX17 = 32'h000008B3;

  initial begin
    logic [6:0] opcs [11];
    logic [31:0] r;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
    for (int k = 0; k < 32; k++) regs[k] = $urandom();
    for (int k = 0; k < 3; k++) drive(0, 32'h0, 32'h0, 0, 0, 1);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_optype", 32'(optype), 32'(T_NOP));
    chk("rst_pc", pc, 32'h0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_data_a", data_a, 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    mon_en = 1'b1;

    drive(1, ADDI, 32'h100, 1, 0, 0);
    chk("addi_valid", 32'(valid), 32'h1);
    chk("addi_opt", 32'(optype), 32'(T_I));
    chk("addi_rd", 32'(rd), 32'h1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    drive(1, SW, 32'h104, 1, 0, 0);
    chk("sw_opt", 32'(optype), 32'(T_ST));
    chk("sw_imm", imm, 32'hFFFFFFFC);
    drive(1, LUI, 32'h108, 1, 0, 0);
    chk("lui_opt", 32'(optype), 32'(T_LUI));
    chk("lui_imm", imm, 32'h12345000);
    drive(1, JAL, 32'h10C, 1, 0, 0);
    chk("jal_opt", 32'(optype), 32'(T_JAL));
    chk("jal_imm", imm, 32'hFFFFFFFE);
    drive(1, BADOP, 32'h110, 1, 0, 0);
    chk("bad_illegal", 32'(illegal), 32'h1);
    chk("bad_imm", imm, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1, ADDX17, 32'h114, 0, 0, 0);
      chk("stall_ready", 32'(ready), 32'h0);
      chk("stall_pc", pc, 32'h110);
    end
    drive(1, ADDX17, 32'h114, 1, 0, 0);
    chk("x17_pc", pc, 32'h114);
    chk("x17_ill32", 32'(illegal), 32'h0);
    chk("x17_ill16", 32'(illegal_e), 32'h1);
    drive(1, ADDI16, 32'h118, 1, 0, 0);
    chk("b2b_pc", pc, 32'h118);
    chk("addi16_ill16", 32'(illegal_e), 32'h0);
    drive(1, ADDI, 32'h11C, 1, 1, 0);
    chk("flush_valid", 32'(valid), 32'h0);
    drive(1, LUI, 32'h120, 1, 0, 0);
    drive(1, ADDI, 32'h124, 0, 0, 0);
    drive(1, ADDI, 32'h128, 0, 0, 1);
    chk("rst_mid_valid", 32'(valid), 32'h0);
    chk("rst_mid_pc", pc, 32'h0);

    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r = {r[31:7], opcs[$urandom_range(0, 10)]};
      drive(1'($urandom_range(0, 9) < 7), r, $urandom(), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end
    for (int k = 0; k < 3; k++) drive(0, 32'h0, 32'h0, 1, 0, 0);
    chk("drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
